tlk2711_axi_slv_mem: RTL
========================

Name: tlk2711_axi_slv_mem

Overview:
Synthesizable AXI4 memory-mapped slave that responds to the tlk2711_top DMA masters. It serves the TX read DMA (AR/R) and the RX write DMA (AW/W/B) from an internal word-addressed memory. It replaces the ad-hoc handshake modelling on the bench and can be placed in hardware as a loopback buffer. The read and write channels are independent, with one outstanding burst per direction.

Parameters:
ADDR_WIDTH, 40, AXI address width
DATA_WIDTH, 128, AXI data width (HP0); BYTES = DATA_WIDTH/8
ID_WIDTH, 4, AXI ID width
MEM_DEPTH, 1024, memory depth in DATA_WIDTH words (power of 2)
BASE_ADDR, 0, byte address of word 0

Ports:
clk  in  1  single clock for all logic
rst_n  in  1  asynchronous, active-low reset
s_axi_awid/awaddr/awlen/awsize/awburst  in  ID/ADDR/8/3/2  write address
s_axi_awvalid  in  1;  s_axi_awready  out  1
s_axi_wdata  in  DATA_WIDTH;  s_axi_wstrb  in  BYTES;  s_axi_wlast  in  1;  s_axi_wvalid  in  1;  s_axi_wready  out  1
s_axi_bid  out  ID;  s_axi_bresp  out  2;  s_axi_bvalid  out  1;  s_axi_bready  in  1
s_axi_arid/araddr/arlen/arsize/arburst  in  ID/ADDR/8/3/2  read address
s_axi_arvalid  in  1;  s_axi_arready  out  1
s_axi_rid  out  ID;  s_axi_rdata  out  DATA_WIDTH;  s_axi_rresp  out  2;  s_axi_rlast  out  1;  s_axi_rvalid  out  1;  s_axi_rready  in  1
o_wr_burst_cnt  out  32  completed B handshakes
o_rd_burst_cnt  out  32  completed rlast handshakes
o_err  out  1  sticky: any SLVERR issued

Behaviour:
- Reset (rst_n low, async): all outputs 0. Both FSMs go to IDLE. Counters and o_err clear. Memory contents are NOT cleared.
- awready and arready are registered; they rise on the first clk edge after rst_n deasserts.
- Address mapping: word index = (addr - BASE_ADDR) >> log2(BYTES). Low address bits are ignored.
- All bursts are treated as INCR of full-width beats. awburst/arburst/awsize/arsize are accepted and ignored.
- Out of range means index >= MEM_DEPTH. There is no wrap-around.
- Write FSM:
  - W_IDLE: awready=1. On AW handshake, latch awid, start index and awlen; clear beat_cnt and err; go to W_DATA.
  - W_DATA: awready=0, wready=1. On each W handshake, write the bytes enabled by wstrb to mem[idx]; idx++, beat_cnt++.
  - A beat that is out of range, or with beat_cnt > awlen, is dropped and sets err.
  - On a handshake with wlast: if beat_cnt != awlen, set err. Then go to W_RESP.
  - W_RESP: wready=0, bvalid=1, bid=latched id, bresp = err ? SLVERR(2'b10) : OKAY(2'b00). Hold until bready.
  - On B handshake: o_wr_burst_cnt++, go to W_IDLE.
- Read FSM:
  - R_IDLE: arready=1. On AR handshake, latch arid, index and arlen; go to R_DATA.
  - On that same edge, load rdata = mem[index] (combinational array read, registered output). rvalid=1 the cycle after AR handshake, so first-beat latency is 1.
  - R_DATA: rdata/rresp/rlast hold stable while rvalid=1 and rready=0.
  - On R handshake when not last: load the next word, so back-to-back beats run at 1 beat/cycle when rready stays high.
  - rlast=1 when beat_cnt == arlen.
  - Out-of-range beat: rdata=0, rresp=SLVERR.
  - On last handshake: rvalid=0, o_rd_burst_cnt++, go to R_IDLE. arready returns 1 on the next cycle.
- Simultaneous read and write of the same word in the same cycle: the read returns the old data and the write lands.
- o_err is set on any SLVERR issued by either channel. It is cleared only by reset.
- Reset mid-burst: the burst is abandoned with no B/R completion. Words already written remain in memory.

Decomposition:
- Package tlk2711_axi_pkg: RESP_OKAY, RESP_SLVERR constants; write-FSM enum (W_IDLE, W_DATA, W_RESP); read-FSM enum (R_IDLE, R_DATA).
- One natural sub-module, tlk2711_axi_slv_ram: MEM_DEPTH x DATA_WIDTH array with a byte-enable write port and an asynchronous read port.
- The FSMs and counters stay in the top.

Test Plan:
- Write: AW addr 0x0, awlen=15, 16 beats data=k, wstrb all-ones, bready=1 -> 16 wready beats, one bvalid with bresp=00 and bid=awid; o_wr_burst_cnt=1.
- Readback: AR addr 0x0, arlen=15, rready=1 -> rvalid one cycle after AR; 16 consecutive beats data=k; rlast only on beat 15; rresp=00.
- Backpressure: toggle rready every other cycle during the readback -> rdata/rlast stable while stalled; 16 beats total; no beat lost or duplicated.
- Partial strobe: write 0xFF..FF to word 2, then wstrb=16'h000F data=0 -> readback word 2 = 0xFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000_0000.
- Out of range: AW index MEM_DEPTH-2, awlen=3 -> 2 beats stored, bresp=10, o_err=1; AR at the same address -> beats 2..3 read zero with rresp=10.
- Reset mid-burst: assert rst_n low after 5 of 16 W beats -> all valid/ready outputs 0 asynchronously; awready=1 one cycle after release; the 5 written words read back intact.

Source files
------------

// File: rtl/tlk2711_axi_pkg.sv
// Shared AXI response codes and FSM state encodings for the DMA-facing memory slave.
package tlk2711_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

endpackage

// File: rtl/tlk2711_axi_slv_ram.sv
// Word-addressed storage: byte-enabled synchronous write, asynchronous read.
module tlk2711_axi_slv_ram #(
    parameter int DATA_WIDTH = 128,
    parameter int MEM_DEPTH  = 1024,
    parameter int ADDR_BITS  = $clog2(MEM_DEPTH)
) (
    input  logic                    clk,
    input  logic                    we_i,
    input  logic [ADDR_BITS-1:0]    waddr_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [ADDR_BITS-1:0]    raddr_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    localparam int BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    // Contents survive reset so a DMA loopback can be inspected after recovery.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tlk2711_axi_slv_mem.sv
// AXI4 memory slave for the tlk2711 DMA masters: one outstanding INCR burst per direction.
module tlk2711_axi_slv_mem
    import tlk2711_axi_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 40,
    parameter int                    DATA_WIDTH = 128,
    parameter int                    ID_WIDTH   = 4,
    parameter int                    MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [31:0]             o_wr_burst_cnt,
    output logic [31:0]             o_rd_burst_cnt,
    output logic                    o_err
);

    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int LSB       = $clog2(BYTES);
    localparam int RAM_AW    = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);

    // Burst type and beat size are fixed by the masters; they are consumed only to keep lint quiet.
    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, s_axi_awsize, s_axi_awburst, s_axi_arsize, s_axi_arburst};

    // ---------------- write channel ----------------
    wr_state_e               wr_state_q;
    logic [ID_WIDTH-1:0]     wr_id_q;
    logic [ADDR_WIDTH-1:0]   wr_idx_q;
    logic [7:0]              wr_len_q;
    logic [8:0]              wr_beat_q;
    logic                    wr_err_q;
    logic                    awready_q, wready_q, bvalid_q, wr_sticky_q;
    logic [1:0]              bresp_q;
    logic [ID_WIDTH-1:0]     bid_q;
    logic [31:0]             wr_cnt_q;

    logic                    aw_hs, w_hs, b_hs;
    logic [ADDR_WIDTH-1:0]   aw_idx;
    logic                    wr_in_range, wr_in_len, ram_we, wr_err_d;

    assign aw_hs       = s_axi_awvalid & awready_q;
    assign w_hs        = s_axi_wvalid & wready_q;
    assign b_hs        = bvalid_q & s_axi_bready;
    assign aw_idx      = (s_axi_awaddr - BASE_ADDR) >> LSB;
    assign wr_in_range = wr_idx_q < DEPTH_A;
    assign wr_in_len   = wr_beat_q <= {1'b0, wr_len_q};
    assign ram_we      = w_hs & wr_in_range & wr_in_len;
    assign wr_err_d    = wr_err_q
                       | (w_hs & ~(wr_in_range & wr_in_len))
                       | (w_hs & s_axi_wlast & (wr_beat_q != {1'b0, wr_len_q}));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q  <= W_IDLE;
            wr_id_q     <= '0;
            wr_idx_q    <= '0;
            wr_len_q    <= '0;
            wr_beat_q   <= '0;
            wr_err_q    <= 1'b0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            bid_q       <= '0;
            wr_cnt_q    <= '0;
            wr_sticky_q <= 1'b0;
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (aw_hs) begin
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b1;
                        wr_id_q    <= s_axi_awid;
                        wr_idx_q   <= aw_idx;
                        wr_len_q   <= s_axi_awlen;
                        wr_beat_q  <= '0;
                        wr_err_q   <= 1'b0;
                        wr_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        wr_idx_q <= wr_idx_q + 1'b1;
                        // Saturate one past awlen so an overlong burst stays flagged.
                        if (wr_in_len) begin
                            wr_beat_q <= wr_beat_q + 9'd1;
                        end
                        wr_err_q <= wr_err_d;
                        if (s_axi_wlast) begin
                            wready_q   <= 1'b0;
                            bvalid_q   <= 1'b1;
                            bid_q      <= wr_id_q;
                            bresp_q    <= wr_err_d ? RESP_SLVERR : RESP_OKAY;
                            wr_state_q <= W_RESP;
                            if (wr_err_d) begin
                                wr_sticky_q <= 1'b1;
                            end
                        end
                    end
                end
                W_RESP: begin
                    if (b_hs) begin
                        bvalid_q   <= 1'b0;
                        awready_q  <= 1'b1;
                        wr_cnt_q   <= wr_cnt_q + 32'd1;
                        wr_state_q <= W_IDLE;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    // ---------------- read channel ----------------
    rd_state_e               rd_state_q;
    logic [ADDR_WIDTH-1:0]   rd_idx_q;
    logic [7:0]              rd_len_q;
    logic [7:0]              rd_beat_q;
    logic                    arready_q, rvalid_q, rlast_q, rd_sticky_q;
    logic [ID_WIDTH-1:0]     rid_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]              rresp_q;
    logic [31:0]             rd_cnt_q;

    logic                    ar_hs, r_hs, rd_load_ok;
    logic [ADDR_WIDTH-1:0]   ar_idx, rd_load_idx;
    logic [DATA_WIDTH-1:0]   ram_rdata;

    assign ar_hs       = s_axi_arvalid & arready_q;
    assign r_hs        = rvalid_q & s_axi_rready;
    assign ar_idx      = (s_axi_araddr - BASE_ADDR) >> LSB;
    // The RAM address always points at the word that the next load will capture.
    assign rd_load_idx = (rd_state_q == R_IDLE) ? ar_idx : rd_idx_q + 1'b1;
    assign rd_load_ok  = rd_load_idx < DEPTH_A;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q  <= R_IDLE;
            rd_idx_q    <= '0;
            rd_len_q    <= '0;
            rd_beat_q   <= '0;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
            rid_q       <= '0;
            rdata_q     <= '0;
            rresp_q     <= RESP_OKAY;
            rd_cnt_q    <= '0;
            rd_sticky_q <= 1'b0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_hs) begin
                        arready_q  <= 1'b0;
                        rid_q      <= s_axi_arid;
                        rd_idx_q   <= ar_idx;
                        rd_len_q   <= s_axi_arlen;
                        rd_beat_q  <= '0;
                        rvalid_q   <= 1'b1;
                        rlast_q    <= (s_axi_arlen == 8'd0);
                        rdata_q    <= rd_load_ok ? ram_rdata : '0;
                        rresp_q    <= rd_load_ok ? RESP_OKAY : RESP_SLVERR;
                        rd_state_q <= R_DATA;
                        if (!rd_load_ok) begin
                            rd_sticky_q <= 1'b1;
                        end
                    end
                end
                R_DATA: begin
                    if (r_hs) begin
                        if (rlast_q) begin
                            rvalid_q   <= 1'b0;
                            rlast_q    <= 1'b0;
                            arready_q  <= 1'b1;
                            rd_cnt_q   <= rd_cnt_q + 32'd1;
                            rd_state_q <= R_IDLE;
                        end else begin
                            rd_idx_q  <= rd_load_idx;
                            rd_beat_q <= rd_beat_q + 8'd1;
                            rlast_q   <= (rd_beat_q + 8'd1 == rd_len_q);
                            rdata_q   <= rd_load_ok ? ram_rdata : '0;
                            rresp_q   <= rd_load_ok ? RESP_OKAY : RESP_SLVERR;
                            if (!rd_load_ok) begin
                                rd_sticky_q <= 1'b1;
                            end
                        end
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    tlk2711_axi_slv_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .ADDR_BITS  (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wr_idx_q[RAM_AW-1:0]),
        .wstrb_i (s_axi_wstrb),
        .wdata_i (s_axi_wdata),
        .raddr_i (rd_load_idx[RAM_AW-1:0]),
        .rdata_o (ram_rdata)
    );

    assign s_axi_awready  = awready_q;
    assign s_axi_wready   = wready_q;
    assign s_axi_bid      = bid_q;
    assign s_axi_bresp    = bresp_q;
    assign s_axi_bvalid   = bvalid_q;
    assign s_axi_arready  = arready_q;
    assign s_axi_rid      = rid_q;
    assign s_axi_rdata    = rdata_q;
    assign s_axi_rresp    = rresp_q;
    assign s_axi_rlast    = rlast_q;
    assign s_axi_rvalid   = rvalid_q;
    assign o_wr_burst_cnt = wr_cnt_q;
    assign o_rd_burst_cnt = rd_cnt_q;
    assign o_err          = wr_sticky_q | rd_sticky_q;

endmodule
